// File: rtl/current_trip_ctrl.sv
// Overcurrent shutdown sequencer: watches four ADC sample streams and drives the power
// switch enable, latching channel or stalled-stream faults and enforcing a re-arm cooldown.
module current_trip_ctrl #(
  parameter int unsigned TRIP_COUNT    = 4,
  parameter int unsigned COOLDOWN_CLKS = 1000000,
  parameter int unsigned STALE_CLKS    = 65536
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic [11:0] adc_data_ch0,
  input  logic [11:0] adc_data_ch1,
  input  logic [11:0] adc_data_ch2,
  input  logic [11:0] adc_data_ch3,
  input  logic        adc_valid_ch0,
  input  logic        adc_valid_ch1,
  input  logic        adc_valid_ch2,
  input  logic        adc_valid_ch3,
  input  logic [11:0] i_thresh,
  input  logic [3:0]  i_ch_en,
  input  logic        i_arm,
  input  logic        i_clear,
  output logic        o_switch_en,
  output logic        o_fault,
  output logic [3:0]  o_fault_ch,
  output logic        o_stale,
  output logic [1:0]  o_state
);

  localparam int unsigned N_CH  = 4;
  localparam int unsigned CNT_W = $clog2(TRIP_COUNT + 1);
  localparam int unsigned WD_W  = $clog2(STALE_CLKS);
  localparam int unsigned CD_W  = (COOLDOWN_CLKS > 1) ? $clog2(COOLDOWN_CLKS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_TRIPPED  = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d, cnt_run;
  logic [WD_W-1:0]            wd_q, wd_d;
  logic [CD_W-1:0]            cd_q, cd_d;
  logic                       sw_d, fault_d, stale_d;
  logic [3:0]                 fault_ch_d;

  logic [N_CH-1:0][11:0] data;
  logic [N_CH-1:0]       valid;
  logic [N_CH-1:0]       trip;
  logic                  any_valid;
  logic                  wd_trip;

  assign data  = {adc_data_ch3, adc_data_ch2, adc_data_ch1, adc_data_ch0};
  assign valid = {adc_valid_ch3, adc_valid_ch2, adc_valid_ch1, adc_valid_ch0};

  // Per-channel consecutive over-threshold counters and the stream watchdog condition
  always_comb begin
    cnt_run = cnt_q;
    trip    = '0;
    for (int n = 0; n < N_CH; n++) begin
      if (!i_ch_en[n]) begin
        cnt_run[n] = '0;
      end else if (valid[n]) begin
        if (data[n] > i_thresh) begin
          if (cnt_q[n] != CNT_W'(TRIP_COUNT)) cnt_run[n] = cnt_q[n] + CNT_W'(1);
          trip[n] = (cnt_run[n] == CNT_W'(TRIP_COUNT));
        end else begin
          cnt_run[n] = '0;
        end
      end
    end
    any_valid = |(valid & i_ch_en);
    wd_trip   = !any_valid && (wd_q == WD_W'(STALE_CLKS - 1));
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wd_q        <= '0;
      cd_q        <= '0;
      o_switch_en <= 1'b0;
      o_fault     <= 1'b0;
      o_fault_ch  <= '0;
      o_stale     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      cd_q        <= cd_d;
      o_switch_en <= sw_d;
      o_fault     <= fault_d;
      o_fault_ch  <= fault_ch_d;
      o_stale     <= stale_d;
    end
  end

  // Next state; counters are zero whenever the FSM is outside RUN
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    wd_d       = '0;
    cd_d       = cd_q;
    sw_d       = 1'b0;
    fault_ch_d = o_fault_ch;
    stale_d    = o_stale;

    unique case (state_q)
      ST_IDLE: begin
        if (i_arm && (i_ch_en != 4'b0000)) begin
          state_d = ST_RUN;
          sw_d    = 1'b1;
        end
      end
      ST_RUN: begin
        if ((|trip) || wd_trip) begin
          state_d    = ST_TRIPPED;
          fault_ch_d = trip;
          stale_d    = wd_trip;
        end else if (!i_arm) begin
          state_d = ST_IDLE;
        end else begin
          sw_d  = 1'b1;
          cnt_d = cnt_run;
          wd_d  = any_valid ? '0 : wd_q + WD_W'(1);
        end
      end
      ST_TRIPPED: begin
        if (i_clear) begin
          state_d = ST_COOLDOWN;
          cd_d    = '0;
        end
      end
      ST_COOLDOWN: begin
        if (cd_q == CD_W'(COOLDOWN_CLKS - 1)) begin
          state_d    = ST_IDLE;
          cd_d       = '0;
          fault_ch_d = '0;
          stale_d    = 1'b0;
        end else begin
          cd_d = cd_q + CD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    fault_d = (state_d == ST_TRIPPED) || (state_d == ST_COOLDOWN);
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_current_trip_ctrl.sv
// Directed bench for current_trip_ctrl: expected outputs queued per step, popped and
// checked one clock later (or immediately for the asynchronous reset check).
module tb_current_trip_ctrl;

  logic        i_Clk = 1'b0;
  logic        i_Rst_L;
  logic [11:0] adc_data_ch0, adc_data_ch1, adc_data_ch2, adc_data_ch3;
  logic        adc_valid_ch0, adc_valid_ch1, adc_valid_ch2, adc_valid_ch3;
  logic [11:0] i_thresh;
  logic [3:0]  i_ch_en;
  logic        i_arm, i_clear;
  logic        o_switch_en, o_fault, o_stale;
  logic [3:0]  o_fault_ch;
  logic [1:0]  o_state;

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];
  string      tag_q[$];

  current_trip_ctrl #(
    .TRIP_COUNT(3), .COOLDOWN_CLKS(16), .STALE_CLKS(64)
  ) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L),
    .adc_data_ch0(adc_data_ch0), .adc_data_ch1(adc_data_ch1),
    .adc_data_ch2(adc_data_ch2), .adc_data_ch3(adc_data_ch3),
    .adc_valid_ch0(adc_valid_ch0), .adc_valid_ch1(adc_valid_ch1),
    .adc_valid_ch2(adc_valid_ch2), .adc_valid_ch3(adc_valid_ch3),
    .i_thresh(i_thresh), .i_ch_en(i_ch_en), .i_arm(i_arm), .i_clear(i_clear),
    .o_switch_en(o_switch_en), .o_fault(o_fault), .o_fault_ch(o_fault_ch),
    .o_stale(o_stale), .o_state(o_state)
  );

  always #5 i_Clk = ~i_Clk;

  // Packed expectation {switch_en, fault, fault_ch, stale, state}
  function automatic logic [8:0] mk(input logic [1:0] st, input logic [3:0] fch, input logic stl);
    logic sw, flt;
    sw  = (st == 2'd1);
    flt = st[1];
    return {sw, flt, fch, stl, st};
  endfunction

  task automatic push_exp(input string tag, input logic [1:0] st, input logic [3:0] fch,
                          input logic stl);
    exp_q.push_back(mk(st, fch, stl));
    tag_q.push_back(tag);
  endtask

  task automatic check_pop();
    logic [8:0] e, obs;
    string t;
    obs = {o_switch_en, o_fault, o_fault_ch, o_stale, o_state};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: observed %b required an expected entry", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: observed {sw,flt,fch,stl,st}=%b expected %b", t, obs, e);
      end
    end
  endtask

  // One clock: drive valids on the masked channels with sample d, check after the edge
  task automatic cyc(input string tag, input logic [3:0] vmask, input logic [11:0] d,
                     input logic [1:0] st, input logic [3:0] fch, input logic stl);
    adc_data_ch0 = d; adc_data_ch1 = d; adc_data_ch2 = d; adc_data_ch3 = d;
    {adc_valid_ch3, adc_valid_ch2, adc_valid_ch1, adc_valid_ch0} = vmask;
    push_exp(tag, st, fch, stl);
    @(posedge i_Clk);
    #1;
    {adc_valid_ch3, adc_valid_ch2, adc_valid_ch1, adc_valid_ch0} = 4'b0000;
    check_pop();
  endtask

  // Clear a latched fault, sit through the cooldown and land in IDLE with flags cleared
  task automatic recover(input string tag, input logic [3:0] fch, input logic stl);
    i_arm   = 1'b0;
    i_clear = 1'b1;
    cyc({tag, "_clear"}, 4'b0, 12'd0, 2'd3, fch, stl);
    i_clear = 1'b0;
    for (int i = 0; i < 15; i++) cyc({tag, "_cool"}, 4'b0, 12'd0, 2'd3, fch, stl);
    cyc({tag, "_idle"}, 4'b0, 12'd0, 2'd0, 4'b0, 1'b0);
  endtask

  initial begin
    i_Rst_L = 1'b0;
    i_thresh = 12'd2000; i_ch_en = 4'hF; i_arm = 1'b0; i_clear = 1'b0;
    adc_data_ch0 = '0; adc_data_ch1 = '0; adc_data_ch2 = '0; adc_data_ch3 = '0;
    {adc_valid_ch3, adc_valid_ch2, adc_valid_ch1, adc_valid_ch0} = 4'b0000;
    #23;
    push_exp("reset", 2'd0, 4'b0, 1'b0);
    check_pop();
    i_Rst_L = 1'b1;
    @(posedge i_Clk); #1;

    // Arming gated by channel enables; arm drop returns to IDLE
    i_ch_en = 4'b0000; i_arm = 1'b1;
    cyc("arm_no_ch", 4'b0, 12'd0, 2'd0, 4'b0, 1'b0);
    i_ch_en = 4'hF;
    cyc("arm", 4'b0, 12'd0, 2'd1, 4'b0, 1'b0);
    i_arm = 1'b0;
    cyc("disarm", 4'b0, 12'd0, 2'd0, 4'b0, 1'b0);

    // ch0 trip after three over-threshold samples
    i_arm = 1'b1;
    cyc("t1_arm", 4'b0, 12'd0, 2'd1, 4'b0, 1'b0);
    cyc("t1_s1", 4'b0001, 12'd2001, 2'd1, 4'b0, 1'b0);
    cyc("t1_s2", 4'b0001, 12'd2001, 2'd1, 4'b0, 1'b0);
    cyc("t1_trip", 4'b0001, 12'd2001, 2'd2, 4'b0001, 1'b0);
    cyc("t1_hold", 4'b0, 12'd0, 2'd2, 4'b0001, 1'b0);

    // Clear held with arm high: 16 clocks of cooldown, IDLE, then RUN
    i_clear = 1'b1;
    cyc("t5_clear", 4'b0, 12'd0, 2'd3, 4'b0001, 1'b0);
    for (int i = 0; i < 15; i++) cyc("t5_cool", 4'b0, 12'd0, 2'd3, 4'b0001, 1'b0);
    cyc("t5_idle", 4'b0, 12'd0, 2'd0, 4'b0, 1'b0);
    cyc("t5_rearm", 4'b0, 12'd0, 2'd1, 4'b0, 1'b0);
    i_clear = 1'b0;

    // ch1: sample equal to threshold breaks the run
    cyc("t2_a", 4'b0010, 12'd2001, 2'd1, 4'b0, 1'b0);
    cyc("t2_b", 4'b0010, 12'd2001, 2'd1, 4'b0, 1'b0);
    cyc("t2_eq", 4'b0010, 12'd2000, 2'd1, 4'b0, 1'b0);
    cyc("t2_c", 4'b0010, 12'd2001, 2'd1, 4'b0, 1'b0);
    cyc("t2_d", 4'b0010, 12'd2001, 2'd1, 4'b0, 1'b0);
    cyc("t2_trip", 4'b0010, 12'd2001, 2'd2, 4'b0010, 1'b0);
    recover("t2", 4'b0010, 1'b0);

    // ch2 ignored while disabled, trips once re-enabled
    i_ch_en = 4'b1011; i_arm = 1'b1;
    cyc("t3_arm", 4'b0, 12'd0, 2'd1, 4'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("t3_dis", 4'b0100, 12'd3000, 2'd1, 4'b0, 1'b0);
    i_ch_en = 4'hF;
    cyc("t3_a", 4'b0100, 12'd2001, 2'd1, 4'b0, 1'b0);
    cyc("t3_b", 4'b0100, 12'd2001, 2'd1, 4'b0, 1'b0);
    cyc("t3_trip", 4'b0100, 12'd2001, 2'd2, 4'b0100, 1'b0);
    recover("t3", 4'b0100, 1'b0);

    // Simultaneous trips on ch0 and ch3
    i_arm = 1'b1;
    cyc("sim_arm", 4'b0, 12'd0, 2'd1, 4'b0, 1'b0);
    cyc("sim_a", 4'b1001, 12'd4095, 2'd1, 4'b0, 1'b0);
    cyc("sim_b", 4'b1001, 12'd4095, 2'd1, 4'b0, 1'b0);
    cyc("sim_trip", 4'b1001, 12'd4095, 2'd2, 4'b1001, 1'b0);
    recover("sim", 4'b1001, 1'b0);

    // Watchdog: no valids for 64 clocks after entering RUN
    i_arm = 1'b1;
    cyc("t4_arm", 4'b0, 12'd0, 2'd1, 4'b0, 1'b0);
    for (int i = 0; i < 63; i++) cyc("t4_wait", 4'b0, 12'd0, 2'd1, 4'b0, 1'b0);
    cyc("t4_stale", 4'b0, 12'd0, 2'd2, 4'b0, 1'b1);
    recover("t4", 4'b0, 1'b1);

    // Async reset mid-count, then counts restart; trip beats arm drop
    i_arm = 1'b1;
    cyc("t6_arm", 4'b0, 12'd0, 2'd1, 4'b0, 1'b0);
    cyc("t6_a", 4'b0001, 12'd2001, 2'd1, 4'b0, 1'b0);
    cyc("t6_b", 4'b0001, 12'd2001, 2'd1, 4'b0, 1'b0);
    #2;
    i_Rst_L = 1'b0;
    #1;
    push_exp("t6_async_rst", 2'd0, 4'b0, 1'b0);
    check_pop();
    #2;
    i_Rst_L = 1'b1;
    cyc("t6_rearm", 4'b0, 12'd0, 2'd1, 4'b0, 1'b0);
    cyc("t6_c", 4'b0001, 12'd2001, 2'd1, 4'b0, 1'b0);
    cyc("t6_d", 4'b0001, 12'd2001, 2'd1, 4'b0, 1'b0);
    i_arm = 1'b0;
    cyc("t6_trip_prio", 4'b0001, 12'd2001, 2'd2, 4'b0001, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
